pe_array_ctrl: RTL and testbench

PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

---
 rtl/pe_ctrl_pkg.sv | 30 +++
 rtl/ctrl_phase_cnt.sv | 41 ++++
 rtl/pe_array_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_pe_array_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pe_ctrl_pkg
// Shared definitions for the PE array controller and PE-side logic:
//   mode_e   - operation encodings broadcast on mode_sel
//   state_e  - controller phase enum
//   max_int  - helper for sizing localparams
// -----------------------------------------------------------------------------
package pe_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_MM    = 2'b00,
    MODE_ILL   = 2'b01,
    MODE_FPMUL = 2'b10,
    MODE_FPADD = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    DRAIN,
    DONE
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ctrl_phase_cnt.sv
// -----------------------------------------------------------------------------
// ctrl_phase_cnt
// Down-counter timing the multi-cycle controller phases.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   load       - reload count with value (wins over dec)
//   value      - reload value
//   dec        - decrement by one (saturates at zero)
//   count      - current count
//   is_last    - count == 1, i.e. the final cycle of the phase
// -----------------------------------------------------------------------------
module ctrl_phase_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         is_last
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign count   = cnt_q;
  assign is_last = (cnt_q == W'(1));

endmodule

// File: rtl/pe_array_ctrl.sv
// -----------------------------------------------------------------------------
// pe_array_ctrl
// Sequencer for a ROWS x COLS systolic PE array. A command is latched in
// IDLE and walked through CLEAR / FEED / FLUSH / DRAIN / DONE.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      - command handshake (ready only in IDLE)
//   cmd_mode/cmd_len/cmd_ysel- command fields, latched on acceptance
//   abort                    - synchronous abort back to IDLE
//   mode_sel, y_sel          - latched command broadcast to the PEs
//   psu_clr                  - partial-sum clear
//   sys_buf_en, drain_row    - drain enable and row index
//   feed_en                  - feeders advance one element
//   busy, done, err          - status; done/err are one-cycle pulses
// All outputs except cmd_ready come straight from flops.
// -----------------------------------------------------------------------------
module pe_array_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int PE_LAT = 3,
  parameter int LEN_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_mode,
  input  logic [LEN_W-1:0]        cmd_len,
  input  logic                    cmd_ysel,
  input  logic                    abort,
  output logic [1:0]              mode_sel,
  output logic                    y_sel,
  output logic                    psu_clr,
  output logic                    sys_buf_en,
  output logic                    feed_en,
  output logic [$clog2(ROWS)-1:0] drain_row,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  // Pipeline depths: matmul waits for the wavefront to cross the whole
  // array; elementwise fp only has to pass down the rows.
  localparam int MM_FLUSH = ROWS + COLS - 2 + PE_LAT;
  localparam int FP_FLUSH = ROWS + PE_LAT - 1;
  localparam int CNT_W    = max_int(LEN_W,
                                    max_int($clog2(MM_FLUSH + 1), $clog2(ROWS + 1)));
  localparam int ROW_W    = $clog2(ROWS);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q;
  logic [1:0]         mode_q;
  logic               ysel_q;
  logic               psu_clr_q, feed_q, sbuf_q, busy_q, done_q, err_q, rdy_q;
  logic [ROW_W-1:0]   row_q;

  logic               accept;
  logic               cnt_load, cnt_dec, cnt_last;
  logic [CNT_W-1:0]   cnt_value, cnt_count;

  // abort outranks a command offered in the same IDLE cycle, so it also
  // masks the handshake.
  assign accept    = (state_q == IDLE) && cmd_valid && !abort;
  assign cmd_ready = rdy_q && !abort;

  ctrl_phase_cnt #(.W(CNT_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .value   (cnt_value),
    .dec     (cnt_dec),
    .count   (cnt_count),
    .is_last (cnt_last)
  );

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_value = '0;
    if ((state_q != IDLE) && abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          if (cmd_mode == MODE_MM) begin
            state_d = CLEAR;
          end else if (cmd_mode == MODE_ILL) begin
            state_d = DONE;
          end else if (cmd_len != '0) begin
            state_d   = FEED;
            cnt_load  = 1'b1;
            cnt_value = CNT_W'(cmd_len);
          end else begin
            state_d   = FLUSH;
            cnt_load  = 1'b1;
            cnt_value = CNT_W'(FP_FLUSH);
          end
        end
        CLEAR: begin
          cnt_load = 1'b1;
          if (len_q != '0) begin
            state_d   = FEED;
            cnt_value = CNT_W'(len_q);
          end else begin
            state_d   = FLUSH;
            cnt_value = CNT_W'(MM_FLUSH);
          end
        end
        FEED: if (cnt_last) begin
          state_d   = FLUSH;
          cnt_load  = 1'b1;
          cnt_value = (mode_q == MODE_MM) ? CNT_W'(MM_FLUSH) : CNT_W'(FP_FLUSH);
        end else begin
          cnt_dec = 1'b1;
        end
        FLUSH: if (cnt_last) begin
          if (mode_q == MODE_MM) begin
            state_d   = DRAIN;
            cnt_load  = 1'b1;
            cnt_value = CNT_W'(ROWS);
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
        DRAIN: if (cnt_last) begin
          state_d = DONE;
        end else begin
          cnt_dec = 1'b1;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state
  // they describe while still coming from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      mode_q    <= MODE_MM;
      ysel_q    <= 1'b0;
      psu_clr_q <= 1'b1;
      feed_q    <= 1'b0;
      sbuf_q    <= 1'b0;
      row_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdy_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) begin
        len_q  <= cmd_len;
        mode_q <= cmd_mode;
        ysel_q <= cmd_ysel;
      end else if (state_d == IDLE) begin
        mode_q <= MODE_MM;
        ysel_q <= 1'b0;
      end
      // An abort leaves the PEs with a clean partial sum for the next command.
      psu_clr_q <= (state_d == CLEAR) || ((state_q != IDLE) && abort);
      feed_q    <= (state_d == FEED);
      sbuf_q    <= (state_d == DRAIN);
      row_q     <= ((state_q == DRAIN) && (state_d == DRAIN)) ? row_q + 1'b1 : '0;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      err_q     <= accept && (cmd_mode == MODE_ILL);
      rdy_q     <= (state_d == IDLE);
    end
  end

  assign mode_sel   = mode_q;
  assign y_sel      = ysel_q;
  assign psu_clr    = psu_clr_q;
  assign feed_en    = feed_q;
  assign sys_buf_en = sbuf_q;
  assign drain_row  = row_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pe_array_ctrl
// Self-checking bench for pe_array_ctrl with ROWS=COLS=4, PE_LAT=3.
// Each command record carries its expected phase lengths; a per-cycle
// expected output trace is queued when the command is driven and popped
// one entry per cycle while the command runs.
// -----------------------------------------------------------------------------
module tb_pe_array_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_ysel, abort;
  logic [1:0]  cmd_mode, mode_sel;
  logic [15:0] cmd_len;
  logic        y_sel, psu_clr, sys_buf_en, feed_en, busy, done, err;
  logic [1:0]  drain_row;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] len;
    logic        ysel;
    int          n_clear;
    int          n_feed;
    int          n_flush;
    int          n_drain;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[7];
  logic [12:0] exp_q[$];

  always #5 clk = ~clk;

  pe_array_ctrl #(.ROWS(4), .COLS(4), .PE_LAT(3), .LEN_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_len    (cmd_len),
    .cmd_ysel   (cmd_ysel),
    .abort      (abort),
    .mode_sel   (mode_sel),
    .y_sel      (y_sel),
    .psu_clr    (psu_clr),
    .sys_buf_en (sys_buf_en),
    .feed_en    (feed_en),
    .drain_row  (drain_row),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Packed view: {ready, busy, done, err, psu_clr, feed_en, sys_buf_en,
  //               drain_row[1:0], mode_sel[1:0], y_sel}
  function automatic logic [12:0] mk(input logic rdy, input logic bsy,
                                     input logic dn, input logic er,
                                     input logic psu, input logic fd,
                                     input logic sb, input logic [1:0] row,
                                     input logic [1:0] md, input logic ys);
    return {rdy, bsy, dn, er, psu, fd, sb, row, md, ys};
  endfunction

  function automatic logic [12:0] obs();
    return {cmd_ready, busy, done, err, psu_clr, feed_en, sys_buf_en,
            drain_row, mode_sel, y_sel};
  endfunction

  localparam logic [12:0] RST_V  = 13'b1_0_0_0_1_0_0_00_00_0;
  localparam logic [12:0] IDLE_V = 13'b1_0_0_0_0_0_0_00_00_0;

  task automatic check(input string name, input logic [12:0] act,
                       input logic [12:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (rdy,busy,done,err,clr,feed,buf,row,mode,ysel)",
               name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_idle: cmd_ready stayed 0 for %0d cycles, required 1", k);
    end
  endtask

  task automatic build_trace(input vec_t v);
    for (int i = 0; i < v.n_clear; i++) exp_q.push_back(mk(0,1,0,0,1,0,0,2'd0,v.mode,v.ysel));
    for (int i = 0; i < v.n_feed;  i++) exp_q.push_back(mk(0,1,0,0,0,1,0,2'd0,v.mode,v.ysel));
    for (int i = 0; i < v.n_flush; i++) exp_q.push_back(mk(0,1,0,0,0,0,0,2'd0,v.mode,v.ysel));
    for (int i = 0; i < v.n_drain; i++) exp_q.push_back(mk(0,1,0,0,0,0,1,2'(i),v.mode,v.ysel));
    exp_q.push_back(mk(0,1,1,v.exp_err,0,0,0,2'd0,v.mode,v.ysel));
    exp_q.push_back(IDLE_V);
  endtask

  task automatic drive(input logic [1:0] md, input logic [15:0] ln, input logic ys);
    cmd_valid = 1'b1;
    cmd_mode  = md;
    cmd_len   = ln;
    cmd_ysel  = ys;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc = 0;
    wait_idle();
    drive(v.mode, v.len, v.ysel);
    build_trace(v);
    @(posedge clk);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cyc++;
      check($sformatf("%s cyc%0d", tag, cyc), obs(), exp_q.pop_front());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // mode, len, ysel, clear, feed, flush, drain, err
    vecs[0] = '{2'b00, 16'd5, 1'b1, 1, 5, 9, 4, 1'b0};
    vecs[1] = '{2'b11, 16'd3, 1'b0, 0, 3, 6, 0, 1'b0};
    vecs[2] = '{2'b00, 16'd0, 1'b0, 1, 0, 9, 4, 1'b0};
    vecs[3] = '{2'b01, 16'd7, 1'b1, 0, 0, 0, 0, 1'b1};
    vecs[4] = '{2'b10, 16'd2, 1'b1, 0, 2, 6, 0, 1'b0};
    vecs[5] = '{2'b10, 16'd0, 1'b0, 0, 0, 6, 0, 1'b0};
    vecs[6] = '{2'b00, 16'd1, 1'b1, 1, 1, 9, 4, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 2'b00; cmd_len = '0;
    cmd_ysel = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    check("reset values", obs(), RST_V);
    rst = 1'b0;
    #1 check("psu_clr held until edge", obs(), RST_V);
    @(negedge clk);
    check("first idle after reset", obs(), IDLE_V);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // abort in IDLE is ignored and blocks a concurrent command
    wait_idle();
    abort = 1'b1;
    drive(2'b00, 16'd5, 1'b0);
    #1 check("idle abort ready", obs(), mk(0,0,0,0,0,0,0,2'd0,2'd0,0));
    @(negedge clk);
    check("idle abort no effect", obs(), mk(0,0,0,0,0,0,0,2'd0,2'd0,0));
    abort = 1'b0;
    cmd_valid = 1'b0;
    #1 check("idle abort released", obs(), IDLE_V);

    // abort during matmul FEED cycle 4
    wait_idle();
    drive(2'b00, 16'd5, 1'b0);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("abort cyc1 clear", obs(), mk(0,1,0,0,1,0,0,2'd0,2'd0,0));
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("abort cyc%0d feed", c), obs(), mk(0,1,0,0,0,1,0,2'd0,2'd0,0));
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1 check("abort cyc5", obs(), mk(1,0,0,0,1,0,0,2'd0,2'd0,0));
    @(negedge clk);
    check("abort cyc6 no done", obs(), IDLE_V);
    run_vec(vecs[0], "post-abort");

    // command offered during DONE waits for the following IDLE cycle
    wait_idle();
    drive(2'b01, 16'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("bubble cyc1 done", obs(), mk(0,1,1,1,0,0,0,2'd0,2'b01,0));
    @(negedge clk);
    check("bubble cyc2 idle", obs(), IDLE_V);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bubble cyc3 done", obs(), mk(0,1,1,1,0,0,0,2'd0,2'b01,0));
    @(negedge clk);
    check("bubble cyc4 idle", obs(), IDLE_V);

    // asynchronous reset in DRAIN (matmul len=0, DRAIN cycles 11-14)
    wait_idle();
    drive(2'b00, 16'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (11) @(negedge clk);
    check("drain row1 before reset", obs(), mk(0,1,0,0,0,0,1,2'd1,2'd0,0));
    #2 rst = 1'b1;
    #1 check("async reset in drain", obs(), RST_V);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      check($sformatf("post-reset idle %0d", c), obs(), IDLE_V);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
